// File: rtl/mips_mc_controller_pkg.sv
// -----------------------------------------------------------------------------
// mips_mc_controller_pkg
// Shared declarations for the MIPS control units:
//   - opcode_t / funct_t : instruction field encodings
//   - state_t            : multicycle controller FSM states (4-bit)
//   - aluop_t            : coarse ALU operation handed to the ALU decoder
//   - ALU_*              : 3-bit alucontrol encodings
//   - REGDST_*/MEMTOREG_*/ALUSRCB_*/PCSRC_* : datapath mux selects
//   - ctrl_t             : bundle of registered Moore control outputs
//   - op_supported()     : opcodes the multicycle controller can sequence
// -----------------------------------------------------------------------------
package mips_mc_controller_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE  = 6'd0,
    OP_BLTGEZ = 6'd1,
    OP_J      = 6'd2,
    OP_JAL    = 6'd3,
    OP_BEQ    = 6'd4,
    OP_BNE    = 6'd5,
    OP_ADDI   = 6'd8,
    OP_ORI    = 6'd13,
    OP_LW     = 6'd35,
    OP_SW     = 6'd43
  } opcode_t;

  typedef enum logic [5:0] {
    FN_ADD = 6'd32,
    FN_SUB = 6'd34,
    FN_AND = 6'd36,
    FN_OR  = 6'd37,
    FN_XOR = 6'd38,
    FN_NOR = 6'd39,
    FN_SLT = 6'd42
  } funct_t;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_BNE    = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11,
    S_JUMP   = 4'd12,
    S_JAL    = 4'd13
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2,
    ALUOP_OR    = 2'd3
  } aluop_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
  localparam logic [1:0] MEMTOREG_PC     = 2'b10;

  localparam logic [1:0] ALUSRCB_B      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       bne_sel;
    aluop_t     aluop;
  } ctrl_t;

  // Opcodes that DECODE dispatches to an execution sequence.
  function automatic logic op_supported(opcode_t op);
    logic ok;
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ORI, OP_LW, OP_SW: ok = 1'b1;
      default:                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips_aludec.sv
// -----------------------------------------------------------------------------
// mips_aludec
// Combinational ALU decoder shared by the single-cycle, multicycle and
// pipelined MIPS controllers.
//   aluop_i      : coarse operation chosen by the controller
//   funct_i      : instr[5:0], consulted only when aluop_i = ALUOP_FUNCT
//   alucontrol_o : 3-bit ALU operation
// Unknown function codes fall back to ADD rather than trapping.
// -----------------------------------------------------------------------------
module mips_aludec
  import mips_mc_controller_pkg::*;
(
  input  aluop_t      aluop_i,
  input  funct_t      funct_i,
  output logic [2:0]  alucontrol_o
);

  // ALU operation from aluop, refined by funct for R-type.
  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_OR:  alucontrol_o = ALU_OR;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alucontrol_o = ALU_ADD;
          FN_SUB:  alucontrol_o = ALU_SUB;
          FN_AND:  alucontrol_o = ALU_AND;
          FN_OR:   alucontrol_o = ALU_OR;
          FN_XOR:  alucontrol_o = ALU_XOR;
          FN_NOR:  alucontrol_o = ALU_NOR;
          FN_SLT:  alucontrol_o = ALU_SLT;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// -----------------------------------------------------------------------------
// mips_mc_controller
// Multicycle MIPS control unit. A Moore FSM sequences each instruction and
// drives the datapath enables and mux selects.
// Ports:
//   clk, reset            : rising-edge clock, async active-high reset
//   opcode, funct, zero   : instr[31:26], instr[5:0], ALU zero flag
//   pcen                  : pcwrite | (branch & (zero ^ bne_sel))
//   iord, memwrite        : memory address select / write strobe
//   irwrite               : instruction register load
//   regdst, memtoreg,
//   regwrite              : register file write port controls
//   alusrca, alusrcb,
//   zeroext, alucontrol   : ALU operand selects and operation
//   pcsrc                 : next-PC select
//   illegal_op            : one-cycle pulse after DECODE of an unsupported opcode
//   state_o               : current FSM state (debug)
// Control outputs are registered: they are computed from the next state, so
// they reflect the current state without a decode stage after the flops.
// Only alucontrol (funct in RTEX) and pcen (zero in BEQ/BNE) see live inputs.
// -----------------------------------------------------------------------------
module mips_mc_controller
  import mips_mc_controller_pkg::*;
#(
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  opcode_t     opcode,
  input  funct_t      funct,
  input  logic        zero,
  output logic        pcen,
  output logic        iord,
  output logic        memwrite,
  output logic        irwrite,
  output logic [1:0]  regdst,
  output logic [1:0]  memtoreg,
  output logic        regwrite,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic        zeroext,
  output logic [1:0]  pcsrc,
  output logic [2:0]  alucontrol,
  output logic        illegal_op,
  output logic [3:0]  state_o
);

  state_t  state_q, state_d;
  opcode_t op_q, op_d;
  ctrl_t   ctrl_q;
  logic    illegal_q, illegal_d;

  // Control values for a state. op is the opcode captured at DECODE; it
  // separates ADDI from ORI without trusting the live instruction bus.
  function automatic ctrl_t ctrl_for(state_t s, opcode_t op);
    ctrl_t c;
    c          = '0;
    c.regdst   = REGDST_RT;
    c.memtoreg = MEMTOREG_ALUOUT;
    c.alusrcb  = ALUSRCB_B;
    c.pcsrc    = PCSRC_ALU;
    c.aluop    = ALUOP_ADD;
    case (s)
      S_FETCH: begin
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.alusrcb = ALUSRCB_FOUR;
      end
      // Branch target is precomputed into ALUOut while registers are read.
      S_DECODE: c.alusrcb = ALUSRCB_IMMSH2;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUSRCB_IMM;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = MEMTOREG_MDR;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_RTEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.regdst   = REGDST_RD;
        c.regwrite = 1'b1;
      end
      S_BEQ, S_BNE: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.branch  = 1'b1;
        c.pcsrc   = PCSRC_ALUOUT;
        c.bne_sel = (s == S_BNE);
      end
      S_IMMEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUSRCB_IMM;
        if (op == OP_ORI) begin
          c.aluop   = ALUOP_OR;
          c.zeroext = 1'b1;
        end else begin
          c.aluop   = ALUOP_ADD;
          c.zeroext = 1'b0;
        end
      end
      S_IMMWB: c.regwrite = 1'b1;
      S_JUMP: begin
        c.pcsrc   = PCSRC_JUMP;
        c.pcwrite = 1'b1;
      end
      // PC already holds PC+4 from FETCH, so it is the link value.
      S_JAL: begin
        c.pcsrc    = PCSRC_JUMP;
        c.pcwrite  = 1'b1;
        c.regdst   = REGDST_RA;
        c.memtoreg = MEMTOREG_PC;
        c.regwrite = 1'b1;
      end
      default: c.irwrite = 1'b0;
    endcase
    return c;
  endfunction

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_RTYPE:        state_d = S_RTEX;
          OP_BEQ:          state_d = S_BEQ;
          OP_BNE:          state_d = S_BNE;
          OP_ADDI, OP_ORI: state_d = S_IMMEX;
          OP_J:            state_d = S_JUMP;
          OP_JAL:          state_d = S_JAL;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op_q == OP_LW) begin
          state_d = S_MEMRD;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_MEMRD: state_d = S_MEMWB;
      S_RTEX:  state_d = S_ALUWB;
      S_IMMEX: state_d = S_IMMWB;
      default: state_d = S_FETCH;
    endcase
  end

  // Opcode capture and illegal-opcode detection, both at DECODE.
  always_comb begin
    op_d      = op_q;
    illegal_d = 1'b0;
    if (state_q == S_DECODE) begin
      op_d      = opcode;
      illegal_d = TRAP_ILLEGAL & ~op_supported(opcode);
    end else begin
      op_d      = op_q;
      illegal_d = 1'b0;
    end
  end

  // State, held opcode and registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= OP_RTYPE;
      ctrl_q    <= ctrl_for(S_FETCH, OP_RTYPE);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ctrl_q    <= ctrl_for(state_d, op_d);
      illegal_q <= illegal_d;
    end
  end

  mips_aludec u_aludec (
    .aluop_i      (ctrl_q.aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol)
  );

  // BNE inverts the sense of zero; outside branch states branch=0 masks it.
  assign pcen       = ctrl_q.pcwrite | (ctrl_q.branch & (zero ^ ctrl_q.bne_sel));
  assign iord       = ctrl_q.iord;
  assign memwrite   = ctrl_q.memwrite;
  assign irwrite    = ctrl_q.irwrite;
  assign regdst     = ctrl_q.regdst;
  assign memtoreg   = ctrl_q.memtoreg;
  assign regwrite   = ctrl_q.regwrite;
  assign alusrca    = ctrl_q.alusrca;
  assign alusrcb    = ctrl_q.alusrcb;
  assign zeroext    = ctrl_q.zeroext;
  assign pcsrc      = ctrl_q.pcsrc;
  assign illegal_op = illegal_q;
  assign state_o    = state_q;

endmodule
